yutorina_regfile_sb: RTL and testbench
======================================

# yutorina_regfile_sb

Parametrised general-purpose register file with a built-in write-pending scoreboard. It is the next-generation GPR for the Yutorina core: configurable width, depth, read-port count and write-port count. It has optional hardwired-zero and write-to-read bypass, and it tracks outstanding producer writes so the decode stage can stall on read-after-write hazards. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2^ADDR_W
- `NUM_RD`, 2, read ports (1..4)
- `NUM_WR`, 2, write ports (1..2)
- `ZERO_REG`, 1, 1 = register 0 reads 0, ignores writes, never busy
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- `clock` in 1: the only clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-low.
- `rd_addr` in NUM_RD*ADDR_W: read addresses; port k is at [k*ADDR_W +: ADDR_W].
- `rd_valid` in NUM_RD: read port k is in use this cycle.
- `rd_data` out NUM_RD*DATA_W: combinational read data.
- `rd_busy` out NUM_RD: combinational; the register addressed by port k has a pending write.
- `stall` out 1: OR over k of (rd_valid[k] & rd_busy[k]).
- `rsv_en` in 1: reserve a register, i.e. mark a new producer in flight.
- `rsv_addr` in ADDR_W: register to reserve.
- `wr_en` in NUM_WR: write enable per port, active-high.
- `wr_addr` in NUM_WR*ADDR_W: write addresses.
- `wr_data` in NUM_WR*DATA_W: write data.
- `flush` in 1: clear all busy bits; register contents are kept.
- `busy_cnt` out ADDR_W+1: registered count of busy registers.

## Operation
- State per register: data word plus busy bit.
- Write, on a clock edge with reset high: for every j with wr_en[j], write wr_data[j] to wr_addr[j] and clear that register's busy bit.
- Write conflict: when two write ports hit the same address, the higher port index wins.
- Reserve: rsv_en sets the busy bit of rsv_addr.
- Reserve and write to the same address in the same cycle: busy ends set (the new producer wins). Data is still written.
- flush: all busy bits end 0 and any same-cycle rsv_en is ignored. Writes in the same cycle still update data.
- ZERO_REG=1, address 0:
  - writes are dropped;
  - rsv_en is dropped;
  - reads return 0;
  - rd_busy is 0.
- Read, BYPASS=1: if any wr_en[j] matches rd_addr[k], rd_data[k] = wr_data of the highest matching j. In that case rd_busy[k] = 0, unless rsv_en targets the same address this cycle.
- Read, BYPASS=0: rd_data is the array contents. rd_busy[k] is the stored busy bit only.
- busy_cnt: popcount of the next-state busy vector, registered. It therefore equals the number of busy registers after each edge.
- Out-of-range parameters (NUM_RD or NUM_WR outside the allowed ranges) stop elaboration with an error.

## Timing
- Read path: zero cycles, combinational from rd_addr/wr_* to rd_data, rd_busy and stall.
- Write-to-read latency:
  - 0 cycles when BYPASS=1;
  - 1 cycle when BYPASS=0, i.e. data is visible after the writing edge.
- Reservation: busy is visible on rd_busy the cycle after the rsv_en edge.
- Reset, on a rising edge with reset = 0:
  - all data words become 0;
  - all busy bits become 0;
  - busy_cnt becomes 0;
  - rsv_en, wr_en and flush are ignored.
- While reset is low:
  - rd_data is forced to 0;
  - rd_busy is forced to 0;
  - stall is forced to 0.
- Reset asserted with reservations pending: all are discarded, no writeback is expected. A write arriving after reset deasserts lands normally.
- busy_cnt range is 0..2^ADDR_W, or 0..2^ADDR_W−1 when ZERO_REG=1.

## Structure
- Shared header `yutorina_regfile.h` holds:
  - default width/depth/port-count defines;
  - the port-slice helper macros;
  - `YUTORINA_RESET_ENABLE` as 0, active-low;
  - the enable encoding.
- Sub-module `yutorina_regfile_scoreboard` holds:
  - the busy vector;
  - the reserve/clear/flush priority logic;
  - the per-read-port busy lookup;
  - the busy_cnt popcount register.
- Top level holds:
  - the data array;
  - write-port arbitration;
  - bypass muxes;
  - zero-register masking.

## Test plan
- **Reset:** write 0xDEADBEEF to r5, then pulse reset low for one edge → reading r5 gives 0, busy_cnt = 0, stall = 0.
- **Bypass (BYPASS=1):** wr_en[0], wr_addr = 7, wr_data = 0x12345678, same cycle rd_addr[0] = 7 → rd_data[0] = 0x12345678 immediately. With BYPASS=0 it appears one cycle later.
- **Write-port conflict:** ports 0 and 1 both write r3 (0xAAAA0000 and 0x5555FFFF) → r3 = 0x5555FFFF.
- **Scoreboard:**
  - reserve r9 → next cycle rd_busy = 1 and stall = 1 with rd_valid set, busy_cnt = 1;
  - write r9 → busy clears, busy_cnt = 0.
  - Reserve and write r9 in the same cycle → busy stays 1.
- **Zero register:** write 0xFFFFFFFF to r0 and reserve r0 → r0 reads 0, rd_busy = 0, busy_cnt unchanged.
- **Flush:** reserve r1, r2 and r4, then flush together with rsv_en on r6 → busy_cnt = 0, no port busy, data words unchanged.

Source files
------------

// File: rtl/yutorina_regfile_pkg.sv
// Shared defaults, port-count limits, reset polarity and enable encoding for the Yutorina GPR.
// No logic of its own; imported by the register file and its scoreboard.
package yutorina_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int MAX_RD     = 4;
  localparam int MAX_WR     = 2;

  localparam logic RESET_ACTIVE = 1'b0;

  typedef enum logic {
    EN_OFF = 1'b0,
    EN_ON  = 1'b1
  } en_t;

  function automatic logic in_reset(input logic rst);
    return rst == RESET_ACTIVE;
  endfunction

endpackage

// File: rtl/yutorina_regfile_sb_scoreboard.sv
// Write-pending scoreboard: busy bit per register, set on reserve, cleared on write or flush.
// Lookup is combinational; busy_cnt is registered (next-state popcount).
// No backpressure; the read-side stall is formed from rd_busy by the top.
module yutorina_regfile_sb_scoreboard
  import yutorina_regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Priority, lowest to highest: write-clear, reserve, flush, zero register.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] == EN_ON) busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (rsv_en == EN_ON) busy_nxt[rsv_addr] = 1'b1;
    if (flush == EN_ON) busy_nxt = '0;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (in_reset(reset)) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] a;
      logic              b;
      logic              hit;
      a   = rd_addr[k*ADDR_W +: ADDR_W];
      b   = busy[a];
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] == EN_ON && wr_addr[j*ADDR_W +: ADDR_W] == a) hit = 1'b1;
      end
      // A forwarded value satisfies the reader unless a new producer claims it now.
      if (BYPASS != 0 && hit) b = (rsv_en == EN_ON) && (rsv_addr == a);
      if ((ZERO_REG != 0 && a == '0) || in_reset(reset)) b = 1'b0;
      rd_busy[k] = b;
    end
  end

endmodule

// File: rtl/yutorina_regfile_sb.sv
// Yutorina GPR: multi-port register file with optional zero register, write bypass and RAW scoreboard.
// Reads are combinational (0-cycle with bypass, 1-cycle otherwise); writes land on the clock edge.
// No backpressure on writes; decode stalls itself through 'stall'.
module yutorina_regfile_sb
  import yutorina_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_num_rd
    $error("yutorina_regfile_sb: NUM_RD must be 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_bad_num_wr
    $error("yutorina_regfile_sb: NUM_WR must be 1..2");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // Ports applied in ascending order so the highest index wins a conflict.
  always_ff @(posedge clock) begin
    if (in_reset(reset)) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] == EN_ON &&
            !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0)) begin
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = rd_addr[k*ADDR_W +: ADDR_W];
      d = mem[a];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] == EN_ON && wr_addr[j*ADDR_W +: ADDR_W] == a) d = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0 && a == '0) || in_reset(reset)) d = '0;
      rd_data[k*DATA_W +: DATA_W] = d;
    end
  end

  yutorina_regfile_sb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

  assign stall = |(rd_valid & rd_busy);

endmodule

// File: tb/tb_yutorina_regfile_sb.sv
// Bench for yutorina_regfile_sb: one bypassing and one non-bypassing instance on shared stimulus.
// Observation word per instance: {rd_data port1, rd_data port0, rd_busy, stall, busy_cnt}.
module tb_yutorina_regfile_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_valid;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        flush;

  wire [63:0] rd_data,  nb_rd_data;
  wire [1:0]  rd_busy,  nb_rd_busy;
  wire        stall,    nb_stall;
  wire [5:0]  busy_cnt, nb_busy_cnt;

  wire [72:0] obs    = {rd_data, rd_busy, stall, busy_cnt};
  wire [72:0] nb_obs = {nb_rd_data, nb_rd_busy, nb_stall, nb_busy_cnt};

  logic [72:0] q [$];
  logic [72:0] ed, en;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  yutorina_regfile_sb dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  yutorina_regfile_sb #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(nb_rd_data), .rd_busy(nb_rd_busy), .stall(nb_stall), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .busy_cnt(nb_busy_cnt)
  );

  task automatic idle();
    rsv_en = 0; rsv_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    flush = 0; rd_valid = 0; rd_addr = 0;
  endtask

  task automatic test_reset();
    reset = 0; rd_addr = {5'd8, 5'd5}; rd_valid = 2'b11;
    repeat (2) @(posedge clock);
    @(negedge clock);
    q.push_back(73'd0); q.push_back(73'd0);
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL reset_hold dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL reset_hold nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    reset = 1; wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    rsv_en = 1; rsv_addr = 5'd8;
    @(negedge clock);
    idle(); rd_addr = {5'd8, 5'd5}; rd_valid = 2'b11;
    q.push_back({32'h0, 32'hDEADBEEF, 2'b10, 1'b1, 6'd1});
    q.push_back({32'h0, 32'hDEADBEEF, 2'b10, 1'b1, 6'd1});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL pre_reset dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL pre_reset nb: got %h want %h", nb_obs, en); end
    reset = 0; wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h1010};
    rsv_en = 1; rsv_addr = 5'd11; rd_addr = {5'd10, 5'd5};
    q.push_back({64'h0, 2'b00, 1'b0, 6'd1}); q.push_back({64'h0, 2'b00, 1'b0, 6'd1});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL reset_force dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL reset_force nb: got %h want %h", nb_obs, en); end
    q.push_back(73'd0); q.push_back(73'd0);
    @(posedge clock); #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL reset_edge dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL reset_edge nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    reset = 1; idle(); rd_addr = {5'd10, 5'd5}; rd_valid = 2'b11;
    q.push_back(73'd0); q.push_back(73'd0);
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL post_reset_data dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL post_reset_data nb: got %h want %h", nb_obs, en); end
    rd_addr = {5'd11, 5'd8};
    q.push_back(73'd0); q.push_back(73'd0);
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL post_reset_busy dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL post_reset_busy nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    idle(); wr_en = 2'b10; wr_addr = {5'd8, 5'd0}; wr_data = {32'h88, 32'h0};
    @(negedge clock);
    idle(); rd_addr = {5'd0, 5'd8}; rd_valid = 2'b01;
    q.push_back({32'h0, 32'h88, 2'b00, 1'b0, 6'd0}); q.push_back({32'h0, 32'h88, 2'b00, 1'b0, 6'd0});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL write_after_reset dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL write_after_reset nb: got %h want %h", nb_obs, en); end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    idle(); rsv_en = 1; rsv_addr = 5'd7;
    @(negedge clock);
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h12345678};
    rd_addr = {5'd0, 5'd7}; rd_valid = 2'b01;
    q.push_back({32'h0, 32'h12345678, 2'b00, 1'b0, 6'd1});
    q.push_back({32'h0, 32'h0, 2'b01, 1'b1, 6'd1});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL bypass_same_cycle dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL bypass_same_cycle nb: got %h want %h", nb_obs, en); end
    q.push_back({32'h0, 32'h12345678, 2'b00, 1'b0, 6'd0});
    q.push_back({32'h0, 32'h12345678, 2'b00, 1'b0, 6'd0});
    @(posedge clock); #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL bypass_next_cycle dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL bypass_next_cycle nb: got %h want %h", nb_obs, en); end
  endtask

  task automatic test_conflict();
    @(negedge clock);
    idle(); wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h5555FFFF, 32'hAAAA0000};
    rd_addr = {5'd3, 5'd3}; rd_valid = 2'b11;
    q.push_back({32'h5555FFFF, 32'h5555FFFF, 2'b00, 1'b0, 6'd0});
    q.push_back({32'h0, 32'h0, 2'b00, 1'b0, 6'd0});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL conflict_bypass dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL conflict_bypass nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    idle(); rd_addr = {5'd3, 5'd3}; rd_valid = 2'b11;
    q.push_back({32'h5555FFFF, 32'h5555FFFF, 2'b00, 1'b0, 6'd0});
    q.push_back({32'h5555FFFF, 32'h5555FFFF, 2'b00, 1'b0, 6'd0});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL conflict_stored dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL conflict_stored nb: got %h want %h", nb_obs, en); end
  endtask

  task automatic test_scoreboard();
    @(negedge clock);
    idle(); rsv_en = 1; rsv_addr = 5'd9; rd_addr = {5'd0, 5'd9}; rd_valid = 2'b01;
    q.push_back(73'd0); q.push_back(73'd0);
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL rsv_not_yet dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL rsv_not_yet nb: got %h want %h", nb_obs, en); end
    q.push_back({64'h0, 2'b01, 1'b1, 6'd1}); q.push_back({64'h0, 2'b01, 1'b1, 6'd1});
    @(posedge clock); #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL rsv_busy dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL rsv_busy nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    rsv_en = 0; rd_valid = 2'b00;
    q.push_back({64'h0, 2'b01, 1'b0, 6'd1}); q.push_back({64'h0, 2'b01, 1'b0, 6'd1});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL stall_needs_valid dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL stall_needs_valid nb: got %h want %h", nb_obs, en); end
    rd_valid = 2'b01; wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    q.push_back({32'h0, 32'h99, 2'b00, 1'b0, 6'd1}); q.push_back({64'h0, 2'b01, 1'b1, 6'd1});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL wr_clear_comb dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL wr_clear_comb nb: got %h want %h", nb_obs, en); end
    q.push_back({32'h0, 32'h99, 2'b00, 1'b0, 6'd0}); q.push_back({32'h0, 32'h99, 2'b00, 1'b0, 6'd0});
    @(posedge clock); #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL wr_clear_edge dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL wr_clear_edge nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h77}; rsv_en = 1; rsv_addr = 5'd9;
    q.push_back({32'h0, 32'h77, 2'b01, 1'b1, 6'd0}); q.push_back({32'h0, 32'h99, 2'b00, 1'b0, 6'd0});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL rsv_wr_comb dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL rsv_wr_comb nb: got %h want %h", nb_obs, en); end
    q.push_back({32'h0, 32'h77, 2'b01, 1'b1, 6'd1}); q.push_back({32'h0, 32'h77, 2'b01, 1'b1, 6'd1});
    @(posedge clock); #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL rsv_wr_edge dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL rsv_wr_edge nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h79};
    @(negedge clock);
    idle(); rd_addr = {5'd0, 5'd9}; rd_valid = 2'b01;
    q.push_back({32'h0, 32'h79, 2'b00, 1'b0, 6'd0}); q.push_back({32'h0, 32'h79, 2'b00, 1'b0, 6'd0});
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL rsv_released dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL rsv_released nb: got %h want %h", nb_obs, en); end
  endtask

  task automatic test_zero();
    @(negedge clock);
    idle(); wr_en = 2'b01; wr_addr = 10'd0; wr_data = {32'h0, 32'hFFFFFFFF};
    rsv_en = 1; rsv_addr = 5'd0; rd_addr = 10'd0; rd_valid = 2'b11;
    q.push_back(73'd0); q.push_back(73'd0);
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL zero_comb dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL zero_comb nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    idle(); rd_addr = 10'd0; rd_valid = 2'b11;
    q.push_back(73'd0); q.push_back(73'd0);
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL zero_stored dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL zero_stored nb: got %h want %h", nb_obs, en); end
  endtask

  task automatic test_flush();
    @(negedge clock);
    idle(); wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'h22, 32'h11};
    @(negedge clock); idle(); rsv_en = 1; rsv_addr = 5'd1;
    @(negedge clock); rsv_addr = 5'd2;
    @(negedge clock); rsv_addr = 5'd4; rd_addr = {5'd2, 5'd1}; rd_valid = 2'b11;
    q.push_back({32'h22, 32'h11, 2'b11, 1'b1, 6'd3}); q.push_back({32'h22, 32'h11, 2'b11, 1'b1, 6'd3});
    @(posedge clock); #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL three_reserved dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL three_reserved nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    rsv_addr = 5'd6; flush = 1;
    q.push_back({32'h22, 32'h11, 2'b00, 1'b0, 6'd0}); q.push_back({32'h22, 32'h11, 2'b00, 1'b0, 6'd0});
    @(posedge clock); #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL flush_edge dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL flush_edge nb: got %h want %h", nb_obs, en); end
    @(negedge clock);
    idle(); rd_addr = {5'd6, 5'd4}; rd_valid = 2'b11;
    q.push_back(73'd0); q.push_back(73'd0);
    #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
    if (obs !== ed) begin miscompares++; $display("FAIL flush_rsv_dropped dut: got %h want %h", obs, ed); end
    if (nb_obs !== en) begin miscompares++; $display("FAIL flush_rsv_dropped nb: got %h want %h", nb_obs, en); end
  endtask

  // Random traffic on r0..r7 against a reference model of contents and busy bits.
  task automatic test_back_to_back();
    logic [31:0] m [32];
    logic        b [32];
    logic [5:0]  cnt;
    logic [63:0] dd, nd;
    logic [1:0]  db, nbb;
    logic [4:0]  a;
    logic        hit;
    @(negedge clock);
    idle(); reset = 0;
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 32; i++) begin m[i] = 32'h0; b[i] = 1'b0; end
    cnt = 6'd0;
    for (int n = 0; n < 300; n++) begin
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data  = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_valid = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        hit = 1'b0;
        dd[k*32 +: 32] = m[a];
        for (int j = 0; j < 2; j++) begin
          if (wr_en[j] && wr_addr[j*5 +: 5] == a) begin hit = 1'b1; dd[k*32 +: 32] = wr_data[j*32 +: 32]; end
        end
        db[k] = hit ? (rsv_en && rsv_addr == a) : b[a];
        nd[k*32 +: 32] = m[a];
        nbb[k] = b[a];
        if (a == 5'd0) begin dd[k*32 +: 32] = 32'h0; nd[k*32 +: 32] = 32'h0; db[k] = 1'b0; nbb[k] = 1'b0; end
      end
      q.push_back({dd, db, |(rd_valid & db), cnt});
      q.push_back({nd, nbb, |(rd_valid & nbb), cnt});
      #1; ed = q.pop_front(); en = q.pop_front(); vectors += 2;
      if (obs !== ed) begin miscompares++; $display("FAIL random[%0d] dut: got %h want %h", n, obs, ed); end
      if (nb_obs !== en) begin miscompares++; $display("FAIL random[%0d] nb: got %h want %h", n, nb_obs, en); end
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wr_addr[j*5 +: 5] != 5'd0) begin
          m[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
          b[wr_addr[j*5 +: 5]] = 1'b0;
        end
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) b[i] = 1'b0;
      end else if (rsv_en && rsv_addr != 5'd0) begin
        b[rsv_addr] = 1'b1;
      end
      cnt = 6'd0;
      for (int i = 0; i < 32; i++) cnt = cnt + {5'd0, b[i]};
      @(negedge clock);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_zero();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
